// File: rtl/alu_retry_seq.sv
// Temporal-redundancy sequencer: runs each ALU op twice, compares the two
// results and retries on disagreement, reporting error and fault statistics.
module alu_retry_seq #(
    parameter int WIDTH     = 32,
    parameter int MAX_RETRY = 3,
    parameter int SWAP      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucont,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cont,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [3:0]       rsp_retries,
    output logic [15:0]      fault_cnt
);

    typedef enum logic [1:0] {IDLE, RUN1, RUN2, RESP} state_t;

    localparam logic [3:0] MAX_TRIES = 4'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, r1;
    logic [2:0]       cont_q;
    logic             z1;
    logic [3:0]       tries;
    logic             match;
    logic             swap_now;

    assign match    = (alu_result == r1) && (alu_zero == z1);
    // Commutative ops (AND/OR/ADD) are re-run with swapped operands so a
    // stuck operand-path fault shows up as a mismatch.
    assign swap_now = (SWAP != 0) && !cont_q[2];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_cont  = cont_q;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid) state_nxt = RUN1;
            end
            RUN1: state_nxt = RUN2;
            RUN2: begin
                if (swap_now) begin
                    alu_a = b_q;
                    alu_b = a_q;
                end
                if (match || tries >= MAX_TRIES) state_nxt = RESP;
                else                             state_nxt = RUN1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            cont_q      <= '0;
            r1          <= '0;
            z1          <= 1'b0;
            tries       <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_retries <= '0;
            fault_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_q    <= a;
                    b_q    <= b;
                    cont_q <= alucont;
                    tries  <= '0;
                end
                RUN1: begin
                    r1 <= alu_result;
                    z1 <= alu_zero;
                end
                RUN2: begin
                    if (match) begin
                        rsp_result  <= alu_result;
                        rsp_zero    <= alu_zero;
                        rsp_err     <= 1'b0;
                        rsp_retries <= tries;
                    end else begin
                        if (fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 16'd1;
                        if (tries < MAX_TRIES) begin
                            tries <= tries + 4'd1;
                        end else begin
                            // Out of retries: report the second run's value, flagged.
                            rsp_result  <= alu_result;
                            rsp_zero    <= alu_zero;
                            rsp_err     <= 1'b1;
                            rsp_retries <= tries;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_retry_seq.sv
// Directed bench for alu_retry_seq: a behavioural ALU with a bench-controlled
// fault mask stands in for the real ALU.
module tb_alu_retry_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       alucont;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [2:0]       alu_cont;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [3:0]       rsp_retries;
    logic [15:0]      fault_cnt;

    logic [WIDTH-1:0] fault_mask;
    logic [WIDTH-1:0] alu_base;
    logic [WIDTH-1:0] run2_a, run2_b;
    logic [2:0]       run2_cont;
    logic             run1_ready;

    int n_tests = 0;
    int n_fail  = 0;

    alu_retry_seq #(.WIDTH(WIDTH), .MAX_RETRY(3), .SWAP(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .alucont(alucont),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .rsp_retries(rsp_retries), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_base = '0;
        case (alu_cont)
            3'b000: alu_base = alu_a & alu_b;
            3'b001: alu_base = alu_a | alu_b;
            3'b010: alu_base = alu_a + alu_b;
            3'b110: alu_base = alu_a - alu_b;
            3'b111: alu_base = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_base = '0;
        endcase
        alu_result = alu_base ^ fault_mask;
        alu_zero   = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request in IDLE; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ic);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        a         = ia;
        b         = ib;
        alucont   = ic;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Walks cycles after acceptance; mode 1 flips bit 0 in the first RUN2,
    // mode 2 flips bit 31 in every RUN2 (even cycles).
    task automatic wait_rsp(input int mode, output int rcyc);
        rcyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            case (mode)
                1:       fault_mask = (k == 2) ? 32'h1 : 32'h0;
                2:       fault_mask = (k % 2 == 0) ? 32'h8000_0000 : 32'h0;
                default: fault_mask = 32'h0;
            endcase
            if (k == 1) run1_ready = req_ready;
            if (k == 2) begin
                run2_a    = alu_a;
                run2_b    = alu_b;
                run2_cont = alu_cont;
            end
            if (rsp_valid) begin
                rcyc = k;
                break;
            end
        end
        fault_mask = '0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_hs_ready", {31'd0, req_ready}, 32'd1);
        check("idle_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int  rcyc;
        bit  stray;
        logic [31:0] held;

        reset      = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        a          = '0;
        b          = '0;
        alucont    = '0;
        fault_mask = '0;
        run1_ready = 1'b0;
        run2_a     = '0;
        run2_b     = '0;
        run2_cont  = '0;

        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_fault_cnt", {16'd0, fault_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ADD, clean
        issue(32'd5, 32'd7, 3'b010);
        wait_rsp(0, rcyc);
        check("add_latency", rcyc, 32'd3);
        check("add_result", rsp_result, 32'd12);
        check("add_zero", {31'd0, rsp_zero}, 32'd0);
        check("add_err", {31'd0, rsp_err}, 32'd0);
        check("add_retries", {28'd0, rsp_retries}, 32'd0);
        check("add_fault_cnt", {16'd0, fault_cnt}, 32'd0);
        check("add_run1_ready", {31'd0, run1_ready}, 32'd0);
        release_rsp();

        // SUB giving zero; non-commutative so no swap
        issue(32'd9, 32'd9, 3'b110);
        wait_rsp(0, rcyc);
        check("sub_latency", rcyc, 32'd3);
        check("sub_result", rsp_result, 32'd0);
        check("sub_zero", {31'd0, rsp_zero}, 32'd1);
        check("sub_run2_a", run2_a, 32'd9);
        check("sub_run2_b", run2_b, 32'd9);
        check("sub_run2_cont", {29'd0, run2_cont}, 32'd6);
        release_rsp();

        // SUB with distinct operands proves no swap on non-commutative ops
        issue(32'd20, 32'd3, 3'b110);
        wait_rsp(0, rcyc);
        check("sub2_run2_a", run2_a, 32'd20);
        check("sub2_result", rsp_result, 32'd17);
        release_rsp();

        // OR with swap, then 5 cycles of backpressure
        issue(32'h0F0, 32'h00F, 3'b001);
        wait_rsp(0, rcyc);
        check("or_latency", rcyc, 32'd3);
        check("or_run2_a", run2_a, 32'h00F);
        check("or_run2_b", run2_b, 32'h0F0);
        check("or_result", rsp_result, 32'h0FF);
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_result", rsp_result, held);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        release_rsp();

        // Transient fault in first RUN2 only
        issue(32'h10, 32'h20, 3'b010);
        wait_rsp(1, rcyc);
        check("tr_latency", rcyc, 32'd5);
        check("tr_result", rsp_result, 32'h30);
        check("tr_retries", {28'd0, rsp_retries}, 32'd1);
        check("tr_err", {31'd0, rsp_err}, 32'd0);
        check("tr_fault_cnt", {16'd0, fault_cnt}, 32'd1);
        release_rsp();

        // Permanent fault from a clean counter
        do_reset();
        issue(32'h10, 32'h20, 3'b010);
        wait_rsp(2, rcyc);
        check("pf_latency", rcyc, 32'd9);
        check("pf_err", {31'd0, rsp_err}, 32'd1);
        check("pf_retries", {28'd0, rsp_retries}, 32'd3);
        check("pf_fault_cnt", {16'd0, fault_cnt}, 32'd4);
        check("pf_result", rsp_result, 32'h8000_0030);
        release_rsp();

        // Reset during the retry RUN2 after one new fault
        issue(32'h3, 32'h4, 3'b010);
        @(negedge clk);
        @(negedge clk);
        fault_mask = 32'h1;
        @(negedge clk);
        fault_mask = 32'h0;
        check("mr_fault_cnt_pre", {16'd0, fault_cnt}, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mr_req_ready", {31'd0, req_ready}, 32'd0);
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_fault_cnt", {16'd0, fault_cnt}, 32'd0);
        check("mr_rsp_result", rsp_result, 32'd0);
        check("mr_alu_a", alu_a, 32'd0);
        check("mr_alu_b", alu_b, 32'd0);
        check("mr_alu_cont", {29'd0, alu_cont}, 32'd0);
        check("mr_rsp_flags", {27'd0, rsp_retries, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_req_ready_post", {31'd0, req_ready}, 32'd1);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) stray = 1'b1;
        end
        check("mr_no_rsp", {31'd0, stray}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
